cnn_out_maxpool2x2: RTL and testbench



---
 rtl/cnn_out_maxpool2x2.sv | 106 ++++++++++
 tb/tb_cnn_out_maxpool2x2.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/cnn_out_maxpool2x2.sv
// Streaming 2x2 / stride-2 max-pool on a raster pixel stream, with a
// pass-through bypass mode. Geometry and mode are latched on each frame's first pixel.
module cnn_out_maxpool2x2 #(
    parameter int N_CH      = 4,
    parameter int PIX_W     = 8,
    parameter int W_SIZE    = 12,
    parameter int MAX_WIDTH = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_pool_en,
    input  logic [W_SIZE-1:0]       i_width,
    input  logic [W_SIZE-1:0]       i_height,
    input  logic [N_CH*PIX_W-1:0]   din,
    input  logic                    vld,
    output logic [N_CH*PIX_W-1:0]   dout,
    output logic                    dout_vld,
    output logic                    frame_done
);
    localparam int DW    = N_CH * PIX_W;
    localparam int DEPTH = MAX_WIDTH / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W_SIZE-1:0] col, row;
    logic [W_SIZE-1:0] width_q, height_q;
    logic              pool_q;
    logic [DW-1:0]     h;
    logic [DW-1:0]     linebuf [DEPTH];

    logic              first;
    logic [W_SIZE-1:0] width_sel, height_sel, width_eff, height_eff;
    logic              pool_sel, last_col, last_row;
    logic [AW-1:0]     lb_idx;
    logic [DW-1:0]     hm, pm;

    function automatic logic [DW-1:0] pmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < N_CH; k++)
            r[k*PIX_W +: PIX_W] = (a[k*PIX_W +: PIX_W] >= b[k*PIX_W +: PIX_W]) ?
                                  a[k*PIX_W +: PIX_W] : b[k*PIX_W +: PIX_W];
        return r;
    endfunction

    // The first pixel of a frame must already see the freshly presented config.
    always_comb begin
        first      = (col == '0) && (row == '0);
        width_sel  = first ? i_width   : width_q;
        height_sel = first ? i_height  : height_q;
        pool_sel   = first ? i_pool_en : pool_q;
        width_eff  = (width_sel  == '0) ? W_SIZE'(1) : width_sel;
        height_eff = (height_sel == '0) ? W_SIZE'(1) : height_sel;
        last_col   = (col == width_eff  - W_SIZE'(1));
        last_row   = (row == height_eff - W_SIZE'(1));
        lb_idx     = AW'(col >> 1);
        hm         = pmax(h, din);
        pm         = pmax(hm, linebuf[lb_idx]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            width_q    <= W_SIZE'(1);
            height_q   <= W_SIZE'(1);
            pool_q     <= 1'b1;
            h          <= '0;
            dout       <= '0;
            dout_vld   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            dout_vld   <= 1'b0;
            frame_done <= 1'b0;
            if (vld) begin
                if (first) begin
                    width_q  <= width_sel;
                    height_q <= height_sel;
                    pool_q   <= pool_sel;
                end
                frame_done <= last_col && last_row;
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + W_SIZE'(1);
                end else begin
                    col <= col + W_SIZE'(1);
                end
                // An odd trailing column/row never reaches the odd-col/odd-row output branch.
                if (!pool_sel) begin
                    dout     <= din;
                    dout_vld <= 1'b1;
                end else if (!col[0]) begin
                    h <= din;
                end else if (row[0]) begin
                    dout     <= pm;
                    dout_vld <= 1'b1;
                end
            end
        end
    end

    // Even rows write, odd rows read: no same-entry read/write conflict, no reset needed.
    always_ff @(posedge clk) begin
        if (vld && pool_sel && col[0] && !row[0])
            linebuf[lb_idx] <= hm;
    end
endmodule

// File: tb/tb_cnn_out_maxpool2x2.sv
// Directed self-checking bench for cnn_out_maxpool2x2.
module tb_cnn_out_maxpool2x2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_pool_en = 1'b1;
    logic [11:0] i_width = 12'd4;
    logic [11:0] i_height = 12'd4;
    logic [31:0] din = '0;
    logic        vld = 1'b0;
    logic [31:0] dout;
    logic        dout_vld;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int n_out = 0;
    int n_fd = 0;

    cnn_out_maxpool2x2 dut (
        .clk(clk), .rst(rst), .i_pool_en(i_pool_en), .i_width(i_width),
        .i_height(i_height), .din(din), .vld(vld), .dout(dout),
        .dout_vld(dout_vld), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dout_vld) n_out++;
        if (frame_done) n_fd++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic px(input logic [31:0] d);
        din = d;
        vld = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_4x4(input string tag);
        int p;
        logic [7:0] mx, mn;
        logic ev;
        i_width = 12'd4; i_height = 12'd4; i_pool_en = 1'b1;
        n_out = 0; n_fd = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                p = r * 4 + c;
                px({8'(15 - p), 8'(15 - p), 8'(15 - p), 8'(p)});
                ev = (r % 2 == 1) && (c % 2 == 1);
                chk({tag, "_vld"}, {31'd0, dout_vld}, {31'd0, ev});
                chk({tag, "_fd"}, {31'd0, frame_done}, {31'd0, (r == 3 && c == 3)});
                if (ev) begin
                    mx = 8'(p);
                    mn = 8'(15 - (p - 5));
                    chk({tag, "_dout"}, dout, {mn, mn, mn, mx});
                end
            end
        end
        idle(2);
        chk({tag, "_nout"}, n_out, 32'd4);
        chk({tag, "_nfd"}, n_fd, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", dout, 32'd0);
        chk("rst_vld", {31'd0, dout_vld}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        idle(2);

        // 4x4 pooled frame
        run_4x4("t4x4");

        // Unsigned compare, 2x2
        i_width = 12'd2; i_height = 12'd2;
        px(32'hFF); px(32'h7F); px(32'h80); px(32'h00);
        chk("uns1_vld", {31'd0, dout_vld}, 32'd1);
        chk("uns1_dout", dout, 32'hFF);
        chk("uns1_fd", {31'd0, frame_done}, 32'd1);
        px(32'h80); px(32'h7F); px(32'h01); px(32'h00);
        chk("uns2_dout", dout, 32'h80);
        chk("uns2_fd", {31'd0, frame_done}, 32'd1);
        idle(2);

        // Odd geometry 5x3, continuous vld; ch0 = r*5+c
        i_width = 12'd5; i_height = 12'd3;
        n_out = 0; n_fd = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 5; c++) begin
                px({24'd0, 8'(r * 5 + c)});
                chk("odd_vld", {31'd0, dout_vld}, {31'd0, (r == 1 && (c == 1 || c == 3))});
                chk("odd_fd", {31'd0, frame_done}, {31'd0, (r == 2 && c == 4)});
                if (r == 1 && c == 1) chk("odd_dout0", dout, 32'd6);
                if (r == 1 && c == 3) chk("odd_dout1", dout, 32'd8);
            end
        end
        idle(2);
        chk("odd_nout", n_out, 32'd2);
        chk("odd_nfd", n_fd, 32'd1);

        // Bypass 128x128 with random gaps
        i_width = 12'd128; i_height = 12'd128; i_pool_en = 1'b0;
        n_out = 0; n_fd = 0;
        for (int i = 0; i < 128 * 128; i++) begin
            d = $urandom;
            px(d);
            chk("byp_dout", dout, d);
            if (i == 128 * 128 - 1) chk("byp_fd", {31'd0, frame_done}, 32'd1);
            if ($urandom_range(0, 3) == 0) begin
                idle($urandom_range(1, 2));
                chk("byp_gap_vld", {31'd0, dout_vld}, 32'd0);
            end
        end
        idle(2);
        chk("byp_nout", n_out, 32'd16384);
        chk("byp_nfd", n_fd, 32'd1);

        // Width change mid-frame: 8x4 frame keeps width 8
        i_width = 12'd8; i_height = 12'd4; i_pool_en = 1'b1;
        n_out = 0; n_fd = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 3) i_width = 12'd4;
            px(32'(i));
        end
        idle(2);
        chk("wchg_nout", n_out, 32'd8);
        chk("wchg_nfd", n_fd, 32'd1);
        n_out = 0; n_fd = 0;
        for (int i = 0; i < 16; i++) px(32'(i));
        idle(2);
        chk("wchg2_nout", n_out, 32'd4);
        chk("wchg2_nfd", n_fd, 32'd1);

        // Reset after 10 pixels, then a full 4x4 frame
        i_width = 12'd4; i_height = 12'd4;
        for (int i = 0; i < 10; i++) px(32'hA5A5A5A5 ^ 32'(i));
        vld = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_dout", dout, 32'd0);
        chk("mrst_vld", {31'd0, dout_vld}, 32'd0);
        chk("mrst_fd", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        idle(1);
        run_4x4("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
